// File: rtl/query_bias_add_stage.sv
// Streaming bias adder: joins matmul lanes with the column bias, aligns
// precision, floors, saturates, and buffers results in a 2-entry FIFO.
module query_bias_add_stage #(
    parameter int DATA_IN_TENSOR_SIZE_DIM_0 = 32,
    parameter int DATA_IN_TENSOR_SIZE_DIM_1 = 8,
    parameter int DATA_IN_PARALLELISM_DIM_0 = 1,
    parameter int DATA_IN_PARALLELISM_DIM_1 = 1,
    parameter int DATA_IN_PRECISION_0       = 16,
    parameter int DATA_IN_PRECISION_1       = 3,
    parameter int BIAS_PRECISION_0          = 16,
    parameter int BIAS_PRECISION_1          = 3,
    parameter int DATA_OUT_PRECISION_0      = 16,
    parameter int DATA_OUT_PRECISION_1      = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic [DATA_IN_PARALLELISM_DIM_0*DATA_IN_PARALLELISM_DIM_1
                  *DATA_IN_PRECISION_0-1:0] data_in,
    input  logic data_in_valid,
    output logic data_in_ready,
    input  logic [DATA_IN_PARALLELISM_DIM_0*BIAS_PRECISION_0-1:0] bias,
    input  logic bias_valid,
    output logic bias_ready,
    output logic [DATA_IN_PARALLELISM_DIM_0*DATA_IN_PARALLELISM_DIM_1
                  *DATA_OUT_PRECISION_0-1:0] data_out,
    output logic data_out_valid,
    input  logic data_out_ready,
    output logic data_out_last
);

    localparam int P0      = DATA_IN_PARALLELISM_DIM_0;
    localparam int P       = P0 * DATA_IN_PARALLELISM_DIM_1;
    localparam int DEPTH_0 = DATA_IN_TENSOR_SIZE_DIM_0 / P0;
    localparam int DEPTH_1 = DATA_IN_TENSOR_SIZE_DIM_1 / DATA_IN_PARALLELISM_DIM_1;

    localparam int IN_W = DATA_IN_PRECISION_0;
    localparam int IN_F = DATA_IN_PRECISION_1;
    localparam int B_W  = BIAS_PRECISION_0;
    localparam int B_F  = BIAS_PRECISION_1;
    localparam int O_W  = DATA_OUT_PRECISION_0;
    localparam int O_F  = DATA_OUT_PRECISION_1;

    localparam int F   = (IN_F > B_F) ? IN_F : B_F;
    localparam int IAW = IN_W + F - IN_F;
    localparam int BAW = B_W + F - B_F;
    localparam int AW  = (IAW > BAW) ? IAW : BAW;
    localparam int SW  = AW + 1;
    localparam int UP  = (O_F > F) ? O_F - F : 0;
    localparam int DN  = (F > O_F) ? F - O_F : 0;
    localparam int QW  = SW + UP;
    localparam int WW  = ((QW > O_W) ? QW : O_W) + 1;
    localparam int CW  = (DEPTH_0 > 1) ? $clog2(DEPTH_0) : 1;
    localparam int RW  = (DEPTH_1 > 1) ? $clog2(DEPTH_1) : 1;

    localparam logic signed [WW-1:0] SAT_HI = WW'((64'sd1 <<< (O_W - 1)) - 64'sd1);
    localparam logic signed [WW-1:0] SAT_LO = ~SAT_HI;

    logic [P*O_W-1:0] sum;
    logic [O_W*P-1:0] buf_d [2];
    logic [1:0]       buf_l;
    logic [1:0]       count;
    logic             wr_ptr;
    logic             rd_ptr;
    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic             fire;
    logic             pop;
    logic             col_end;
    logic             row_end;

    for (genvar j = 0; j < P; j++) begin : g_lane
        logic signed [SW-1:0]  a;
        logic signed [SW-1:0]  b;
        logic signed [SW-1:0]  s;
        logic signed [QW-1:0]  q;
        logic signed [WW-1:0]  w;
        logic        [O_W-1:0] sat;

        // Bias lane is picked by column only: broadcast across dim 1.
        always_comb begin
            a = SW'($signed(data_in[j*IN_W +: IN_W])) <<< (F - IN_F);
            b = SW'($signed(bias[(j % P0)*B_W +: B_W])) <<< (F - B_F);
            s = a + b;
            q = (QW'(s) <<< UP) >>> DN;
            w = WW'(q);
            if (w > SAT_HI) begin
                sat = SAT_HI[O_W-1:0];
            end else if (w < SAT_LO) begin
                sat = SAT_LO[O_W-1:0];
            end else begin
                sat = w[O_W-1:0];
            end
        end

        assign sum[j*O_W +: O_W] = sat;
    end

    // Readies depend only on local state, never on data_out_ready.
    assign fire          = data_in_valid & bias_valid & ~count[1] & ~rst;
    assign data_in_ready = fire;
    assign bias_ready    = fire;

    assign pop            = (count != 2'd0) & data_out_ready;
    assign data_out_valid = (count != 2'd0);
    assign data_out       = buf_d[rd_ptr];
    assign data_out_last  = buf_l[rd_ptr];

    assign col_end = (col == CW'(DEPTH_0 - 1));
    assign row_end = (row == RW'(DEPTH_1 - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            col      <= '0;
            row      <= '0;
            buf_d[0] <= '0;
            buf_d[1] <= '0;
            buf_l    <= 2'b00;
        end else begin
            if (fire) begin
                buf_d[wr_ptr] <= sum;
                buf_l[wr_ptr] <= col_end & row_end;
                wr_ptr        <= ~wr_ptr;
                if (col_end) begin
                    col <= '0;
                    row <= row_end ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({fire, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_query_bias_add_stage.sv
// Bench for query_bias_add_stage: three configurations checked against a
// queue-based reference and a fixed-point model using a common denominator.
module tb_query_bias_add_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    // u0: 16/3 everywhere, 4x2 tensor, one lane
    logic [15:0] d0_in, d0_bias, d0_out;
    logic        d0_iv, d0_ir, d0_bv, d0_br, d0_ov, d0_or, d0_last;
    // u1: in 16/3, bias 16/1, out 16/2, 2x2 lanes, 4x2 tensor
    logic [63:0] d1_in, d1_out;
    logic [31:0] d1_bias;
    logic        d1_iv, d1_ir, d1_bv, d1_br, d1_ov, d1_or, d1_last;
    // u2: in 12/2, bias 16/1, out 10/4, one lane, 3x2 tensor
    logic [11:0] d2_in;
    logic [15:0] d2_bias;
    logic [9:0]  d2_out;
    logic        d2_iv, d2_ir, d2_bv, d2_br, d2_ov, d2_or, d2_last;

    query_bias_add_stage #(
        .DATA_IN_TENSOR_SIZE_DIM_0(4), .DATA_IN_TENSOR_SIZE_DIM_1(2)
    ) u0 (
        .clk(clk), .rst(rst),
        .data_in(d0_in), .data_in_valid(d0_iv), .data_in_ready(d0_ir),
        .bias(d0_bias), .bias_valid(d0_bv), .bias_ready(d0_br),
        .data_out(d0_out), .data_out_valid(d0_ov),
        .data_out_ready(d0_or), .data_out_last(d0_last)
    );

    query_bias_add_stage #(
        .DATA_IN_TENSOR_SIZE_DIM_0(4), .DATA_IN_TENSOR_SIZE_DIM_1(2),
        .DATA_IN_PARALLELISM_DIM_0(2), .DATA_IN_PARALLELISM_DIM_1(2),
        .BIAS_PRECISION_1(1), .DATA_OUT_PRECISION_1(2)
    ) u1 (
        .clk(clk), .rst(rst),
        .data_in(d1_in), .data_in_valid(d1_iv), .data_in_ready(d1_ir),
        .bias(d1_bias), .bias_valid(d1_bv), .bias_ready(d1_br),
        .data_out(d1_out), .data_out_valid(d1_ov),
        .data_out_ready(d1_or), .data_out_last(d1_last)
    );

    query_bias_add_stage #(
        .DATA_IN_TENSOR_SIZE_DIM_0(3), .DATA_IN_TENSOR_SIZE_DIM_1(2),
        .DATA_IN_PRECISION_0(12), .DATA_IN_PRECISION_1(2),
        .BIAS_PRECISION_1(1),
        .DATA_OUT_PRECISION_0(10), .DATA_OUT_PRECISION_1(4)
    ) u2 (
        .clk(clk), .rst(rst),
        .data_in(d2_in), .data_in_valid(d2_iv), .data_in_ready(d2_ir),
        .bias(d2_bias), .bias_valid(d2_bv), .bias_ready(d2_br),
        .data_out(d2_out), .data_out_valid(d2_ov),
        .data_out_ready(d2_or), .data_out_last(d2_last)
    );

    task automatic expect_eq(string name, logic signed [63:0] act,
                             logic signed [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_bit(string name, logic act, logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Real values scaled by 2^8, added, then floored to the output scale.
    function automatic longint model(longint d, longint b, int inf, int bf,
                                     int of, int ow);
        longint s, r, hi, lo;
        s  = (d <<< (8 - inf)) + (b <<< (8 - bf));
        r  = s >>> (8 - of);
        hi = (64'sd1 <<< (ow - 1)) - 1;
        lo = -hi - 1;
        if (r > hi) r = hi;
        if (r < lo) r = lo;
        return r;
    endfunction

    function automatic longint rnds(int w);
        longint x;
        x = longint'($urandom) & ((64'sd1 <<< w) - 1);
        if (x >= (64'sd1 <<< (w - 1))) x = x - (64'sd1 <<< w);
        return x;
    endfunction

    typedef struct {
        longint v;
        bit     l;
    } ent_t;

    ent_t q0[$];
    int   m_beat = 0;

    // One u0 clock: drive, check at negedge against the queue, update model.
    task automatic cyc(bit iv, bit bv, longint din, longint bs, bit ordy, bit r);
        bit exp_rdy;
        d0_iv   = iv;
        d0_bv   = bv;
        d0_in   = din[15:0];
        d0_bias = bs[15:0];
        d0_or   = ordy;
        rst     = r;
        exp_rdy = iv && bv && (q0.size() < 2) && !r;
        @(negedge clk);
        expect_bit("in_ready", d0_ir, exp_rdy);
        expect_bit("bias_ready", d0_br, exp_rdy);
        expect_bit("out_valid", d0_ov, q0.size() != 0);
        if (q0.size() != 0) begin
            expect_eq("out_data", 64'($signed(d0_out)), q0[0].v);
            expect_bit("out_last", d0_last, q0[0].l);
        end
        @(posedge clk);
        if (r) begin
            q0.delete();
            m_beat = 0;
        end else begin
            if (q0.size() != 0 && ordy) void'(q0.pop_front());
            if (exp_rdy) begin
                q0.push_back('{model(din, bs, 3, 3, 3, 16), m_beat == 7});
                m_beat = (m_beat + 1) % 8;
            end
        end
        #1;
    endtask

    typedef struct {
        longint din;
        longint bs;
        longint exp;
    } vec_t;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not end, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t   tbl[8];
        vec_t   t1[3];
        vec_t   t2[3];
        longint colb[4];
        longint l1[4];
        longint b1[2];
        longint x2, y2;

        tbl[0] = '{100, 25, 125};
        tbl[1] = '{32767, 1, 32767};
        tbl[2] = '{-32768, -1, -32768};
        tbl[3] = '{32760, -5, 32755};
        tbl[4] = '{-100, 30, -70};
        tbl[5] = '{0, 0, 0};
        tbl[6] = '{-1, -1, -2};
        tbl[7] = '{16384, 16384, 32767};
        t1[0]  = '{7, 0, 3};
        t1[1]  = '{-7, 0, -4};
        t1[2]  = '{0, 1, 2};
        t2[0]  = '{1, 0, 4};
        t2[1]  = '{0, 1, 8};
        t2[2]  = '{2047, 0, 511};

        {d1_in, d1_bias, d1_iv, d1_bv, d1_or} = '0;
        {d2_in, d2_bias, d2_iv, d2_bv, d2_or} = '0;
        {d0_in, d0_bias, d0_iv, d0_bv, d0_or} = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset with both valids high: readies must stay low.
        cyc(1, 1, 5, 5, 1, 1);
        expect_bit("rst_valid", d0_ov, 1'b0);
        expect_bit("rst_last", d0_last, 1'b0);
        expect_eq("rst_data", 64'(d0_out), 0);

        // Table: single beats, result visible one edge after acceptance.
        for (int i = 0; i < 8; i++) begin
            cyc(1, 1, tbl[i].din, tbl[i].bs, 1, 0);
            expect_bit("tbl_valid", d0_ov, 1'b1);
            expect_eq("tbl_data", 64'($signed(d0_out)), tbl[i].exp);
            expect_bit("tbl_last", d0_last, i == 7);
            cyc(0, 0, 0, 0, 1, 0);
        end

        // Back-to-back tensor with a per-column bias vector.
        for (int k = 0; k < 4; k++) colb[k] = rnds(10);
        for (int k = 0; k < 8; k++) cyc(1, 1, rnds(16), colb[k % 4], 1, 0);
        repeat (2) cyc(0, 0, 0, 0, 1, 0);

        // Backpressure, then release with valids still high.
        repeat (5) cyc(1, 1, rnds(16), rnds(16), 0, 0);
        repeat (4) cyc(1, 1, rnds(16), rnds(16), 1, 0);
        repeat (3) cyc(0, 0, 0, 0, 1, 0);

        // Partner stream missing: nothing consumed.
        repeat (3) cyc(1, 0, rnds(16), 0, 1, 0);
        repeat (2) cyc(0, 1, 0, rnds(16), 1, 0);
        cyc(1, 1, rnds(16), rnds(16), 1, 0);
        cyc(0, 0, 0, 0, 1, 0);

        // Reset mid-stream, then a fresh tensor.
        repeat (3) cyc(1, 1, rnds(16), rnds(16), 0, 0);
        cyc(1, 1, 1, 1, 0, 1);
        expect_bit("midrst_valid", d0_ov, 1'b0);
        for (int k = 0; k < 8; k++) cyc(1, 1, rnds(16), rnds(16), 1, 0);
        repeat (2) cyc(0, 0, 0, 0, 1, 0);

        // Random traffic against the queue model.
        for (int k = 0; k < 400; k++) begin
            cyc($urandom_range(3) != 0, $urandom_range(3) != 0,
                ($urandom_range(7) == 0) ? 32767 : rnds(16), rnds(16),
                $urandom_range(4) > 1, $urandom_range(99) == 0);
        end
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);

        // u1: 2x2 lanes, bias broadcast over dim 1, requantise down.
        for (int i = 0; i < 40; i++) begin
            for (int j = 0; j < 4; j++) l1[j] = rnds(16);
            for (int j = 0; j < 2; j++) b1[j] = rnds(16);
            if (i < 3) begin
                l1[0] = t1[i].din;
                b1[0] = t1[i].bs;
            end
            for (int j = 0; j < 4; j++) d1_in[j*16 +: 16] = l1[j][15:0];
            for (int j = 0; j < 2; j++) d1_bias[j*16 +: 16] = b1[j][15:0];
            d1_iv = 1'b1;
            d1_bv = 1'b1;
            d1_or = 1'b1;
            #1;
            expect_bit("u1_ready", d1_ir, 1'b1);
            @(posedge clk);
            #1;
            d1_iv = 1'b0;
            d1_bv = 1'b0;
            expect_bit("u1_valid", d1_ov, 1'b1);
            expect_bit("u1_last", d1_last, (i % 2) == 1);
            for (int j = 0; j < 4; j++) begin
                expect_eq("u1_lane", 64'($signed(d1_out[j*16 +: 16])),
                          model(l1[j], b1[j % 2], 3, 1, 2, 16));
            end
            if (i < 3) expect_eq("u1_tbl", 64'($signed(d1_out[15:0])), t1[i].exp);
            @(posedge clk);
            #1;
            expect_bit("u1_drained", d1_ov, 1'b0);
        end

        // u2: requantise up with narrow saturation, 3-column wrap.
        for (int i = 0; i < 36; i++) begin
            x2 = rnds(12);
            y2 = ($urandom_range(1) == 0) ? rnds(8) : rnds(16);
            if (i < 3) begin
                x2 = t2[i].din;
                y2 = t2[i].bs;
            end
            d2_in   = x2[11:0];
            d2_bias = y2[15:0];
            d2_iv   = 1'b1;
            d2_bv   = 1'b1;
            d2_or   = 1'b1;
            @(posedge clk);
            #1;
            d2_iv = 1'b0;
            d2_bv = 1'b0;
            expect_bit("u2_valid", d2_ov, 1'b1);
            expect_bit("u2_last", d2_last, (i % 6) == 5);
            expect_eq("u2_data", 64'($signed(d2_out)), model(x2, y2, 2, 1, 4, 10));
            if (i < 3) expect_eq("u2_tbl", 64'($signed(d2_out)), t2[i].exp);
            @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
